// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus between a boot source and the loader.
// The slave modport is the loader's view; the master modport is the environment.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 7
) ();
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into instruction words, writes them to
// imem and releases the core only after a full program with a matching XOR checksum.
//
// state  | meaning
// -------+---------------------------------------------------------
// HDR_HI | waiting for word-count high byte; counters cleared here
// HDR_LO | waiting for word-count low byte; range-checks the count
// DATA   | assembling payload words and writing them to imem
// CHECK  | waiting for the checksum byte
// DONE   | program loaded and verified; core released
// ERROR  | oversize count or checksum mismatch; core stays held
module imem_loader #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    imem_loader_if.slave          bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    state_t                state_q;
    state_t                state_d;
    logic [7:0]            cnt_hi_q;
    logic [15:0]           count_q;
    logic [7:0]            xor_q;
    logic [23:0]           asm_q;
    logic [1:0]            byte_cnt_q;
    logic [ADDR_WIDTH:0]   words_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  ready_st;
    logic                  accept;
    logic [15:0]           count_n;
    logic [ADDR_WIDTH:0]   words_inc;
    logic                  last_word;

    assign ready_st  = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                       (state_q == DATA)   || (state_q == CHECK);
    assign bus.in_ready = ready_st && !start;
    assign accept    = bus.in_ready && bus.in_valid;
    assign count_n   = {cnt_hi_q, bus.in_data};
    assign words_inc = words_q + 1'b1;
    // A word completes on its 4th byte; the load completes when that word is the Nth.
    assign last_word = (byte_cnt_q == 2'd3) &&
                       ({{(15 - ADDR_WIDTH){1'b0}}, words_inc} == count_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = HDR_HI;
        end else if (accept) begin
            unique case (state_q)
                HDR_HI: state_d = HDR_LO;
                HDR_LO: begin
                    if ({1'b0, count_n} > DEPTH) state_d = ERROR;
                    else if (count_n == 16'd0)   state_d = CHECK;
                    else                         state_d = DATA;
                end
                DATA:   if (last_word) state_d = CHECK;
                CHECK:  state_d = (bus.in_data == xor_q) ? DONE : ERROR;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_hi_q   <= '0;
            count_q    <= '0;
            xor_q      <= '0;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            words_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                xor_q      <= '0;
                asm_q      <= '0;
                byte_cnt_q <= '0;
                words_q    <= '0;
            end else if (accept) begin
                unique case (state_q)
                    HDR_HI: begin
                        cnt_hi_q   <= bus.in_data;
                        xor_q      <= '0;
                        byte_cnt_q <= '0;
                        words_q    <= '0;
                    end
                    HDR_LO: count_q <= count_n;
                    DATA: begin
                        asm_q      <= {asm_q[15:0], bus.in_data};
                        xor_q      <= xor_q ^ bus.in_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= words_q[ADDR_WIDTH-1:0];
                            wdata_q <= {asm_q, bus.in_data};
                            words_q <= words_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign words_loaded   = words_q;
    assign cpu_hold       = (state_q != DONE);
    assign done           = (state_q == DONE);
    assign error          = (state_q == ERROR);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected imem writes are queued by the stimulus and
// checked by an independent write monitor; status outputs are checked inline.
module tb_imem_loader;
    localparam int AW = 7;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            cpu_hold;
    logic            done;
    logic            error;
    logic [AW:0]     words_loaded;

    int nvec = 0;
    int nmis = 0;

    logic [AW+31:0] exp_q[$];
    logic [7:0]     prog[11] = '{8'h00, 8'h02, 8'h08, 8'h01, 8'h00, 8'h05,
                                 8'h00, 8'h22, 8'h10, 8'h02, 8'h3C};

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every imem_we cycle must match the oldest queued write.
    always @(negedge clock) begin
        if (!reset && bus.imem_we === 1'b1) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nmis++;
                $display("FAIL unexpected_write: addr %h data %h, none expected",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== e) begin
                    nmis++;
                    $display("FAIL imem_write: got addr %h data %h expected addr %h data %h",
                             bus.imem_addr, bus.imem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
    end

    // Present one byte and return #1 after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        int  tries = 0;
        logic ok;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clock);
            ok = bus.in_ready;
            @(posedge clock);
            tries++;
        end while (!ok && tries < 200);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            nvec++;
            nmis++;
            $display("FAIL send_timeout: byte %h never accepted, in_ready stayed 0", b);
        end
    endtask

    task automatic send_prog(input int n, input logic [7:0] last, input int gap);
        for (int i = 0; i < n; i++) begin
            send_byte((i == 10) ? last : prog[i]);
            if (gap > 0 && i != n - 1) repeat (gap) @(posedge clock);
            if (gap > 0 && i != n - 1) #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic push_two_words();
        exp_q.push_back({7'd0, 32'h08010005});
        exp_q.push_back({7'd1, 32'h00221002});
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done_error", {30'd0, done, error}, 32'd0);
        chk("rst_write_bus", {24'd0, bus.imem_we, bus.imem_addr}, 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        reset = 1'b0;

        // Two-word load with good checksum.
        push_two_words();
        send_prog(10, 8'h3C, 0);
        chk("good_done_before_chk", {31'd0, done}, 32'd0);
        send_byte(8'h3C);
        chk("good_done", {31'd0, done}, 32'd1);
        chk("good_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("good_words_loaded", {24'd0, words_loaded}, 32'd2);
        chk("good_addr_hold", {25'd0, bus.imem_addr}, 32'd1);
        chk("good_wdata_hold", bus.imem_wdata, 32'h00221002);
        chk("good_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("good_queue_empty", exp_q.size(), 32'd0);

        // Bad checksum: both words still written, then error.
        pulse_start();
        push_two_words();
        send_prog(11, 8'h3D, 0);
        chk("bad_error_done", {30'd0, error, done}, 32'd2);
        chk("bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("bad_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bad_queue_empty", exp_q.size(), 32'd0);

        // Empty program.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_words", {24'd0, words_loaded}, 32'd0);

        // Oversize count 0x81 > 128.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h81);
        chk("oversize_error", {31'd0, error}, 32'd1);
        chk("oversize_in_ready", {31'd0, bus.in_ready}, 32'd0);

        // Maximum count 0x80 is accepted and enters DATA (in_ready stays high).
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h80);
        chk("max_count_no_error", {30'd0, error, bus.in_ready}, 32'd1);

        // Backpressure gaps of 3 cycles between bytes.
        pulse_start();
        push_two_words();
        send_prog(11, 8'h3C, 3);
        chk("gap_done", {31'd0, done}, 32'd1);
        chk("gap_words", {24'd0, words_loaded}, 32'd2);
        chk("gap_queue_empty", exp_q.size(), 32'd0);

        // start mid-load, coincident with a valid byte.
        pulse_start();
        exp_q.push_back({7'd0, 32'h08010005});
        send_prog(6, 8'h3C, 0);
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b1;
        start        = 1'b1;
        #1;
        chk("start_blocks_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clock);
        #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        chk("start_words_cleared", {24'd0, words_loaded}, 32'd0);
        push_two_words();
        send_prog(11, 8'h3C, 0);
        chk("restart_done", {31'd0, done}, 32'd1);
        chk("restart_queue_empty", exp_q.size(), 32'd0);

        // reset during DATA.
        pulse_start();
        send_prog(5, 8'h3C, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrst_in_ready_hold", {30'd0, bus.in_ready, cpu_hold}, 32'd3);
        chk("midrst_done_error", {30'd0, done, error}, 32'd0);
        chk("midrst_words", {24'd0, words_loaded}, 32'd0);
        chk("midrst_addr_we", {24'd0, bus.imem_we, bus.imem_addr}, 32'd0);
        chk("midrst_wdata", bus.imem_wdata, 32'd0);

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses of instruction memory. It holds the core off (`cpu_hold`) until a complete program with a matching checksum has been written. It is the write-side counterpart of the instruction fetch path: it fills the memory that `pc/4` indexes.

## Interface

**Parameters**
- `ADDR_WIDTH`, 7, instruction-memory word-address width; depth = 2^ADDR_WIDTH words.

**Ports**
- `clock`  in  1  single clock; everything is posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; aborts any load and restarts at header.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH  word index (byte address / 4).
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  core held (PC frozen at 0) while high.
- `done`  out  1  load succeeded; sticky.
- `error`  out  1  load failed; sticky.
- `words_loaded`  out  ADDR_WIDTH+1  number of words written so far.

## Operation

- **Stream format:** `CNT_HI`, `CNT_LO` (16-bit word count N, big-endian), then N×4 payload bytes (each word MSB first), then one checksum byte.
- **Checksum:** XOR of all payload bytes. Header bytes are excluded.
- **States:** `HDR_HI`, `HDR_LO`, `DATA`, `CHECK`, `DONE`, `ERROR`.
- **Byte acceptance:** `in_ready` = 1 in `HDR_HI`, `HDR_LO`, `DATA` and `CHECK`; 0 in `DONE` and `ERROR`. A byte is consumed only when `in_valid && in_ready`.
- **`HDR_HI`:** latch count[15:8] and clear the running XOR, byte counter and `words_loaded`. Next state `HDR_LO`.
- **`HDR_LO`:** latch count[7:0]. Then:
  - N > 2^ADDR_WIDTH → `ERROR`.
  - N = 0 → `CHECK`.
  - otherwise → `DATA`.
- **`DATA`:**
  - Each accepted byte shifts into a 32-bit assembly register (left shift, new byte in [7:0]) and XORs into the checksum.
  - A 2-bit byte counter wraps 3→0.
  - On the 4th byte the word is committed: `imem_addr` = `words_loaded`[ADDR_WIDTH-1:0], then `words_loaded` increments.
  - When `words_loaded` reaches N (the last word's 4th byte is accepted) → `CHECK`.
- **`CHECK`:** the accepted byte is compared to the running XOR. Equal → `DONE`; unequal → `ERROR`.
- **`DONE` / `ERROR`:** held until `start` or `reset`.
  - `cpu_hold` = 0 only in `DONE`; it is 1 in every other state.
  - `done` = 1 only in `DONE`; `error` = 1 only in `ERROR`.
- **`start`:** in any state, next state is `HDR_HI` and all counters and XOR are cleared. A byte presented in the same cycle as `start` is not consumed (`in_ready` is forced to 0 while `start` = 1). Memory contents already written are not erased.
- **Address wrap:** N = 2^ADDR_WIDTH writes every address exactly once, with no wrap. N > depth never reaches `DATA`.

## Timing

- **Reset values:**
  - state `HDR_HI`.
  - `in_ready` = 1, `cpu_hold` = 1.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `done` = 0, `error` = 0, `words_loaded` = 0.
- **Write latency:** `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid for exactly one cycle, the cycle after the 4th byte of a word is accepted. `imem_addr` and `imem_wdata` hold their values after `imem_we` drops.
- **Throughput:** one byte per cycle sustained. `in_valid` gaps stall without losing state.
- **Completion latency:** `done`/`error` and `cpu_hold` change the cycle after the checksum byte is accepted. For oversize N, `error` rises the cycle after `CNT_LO` is accepted.
- **Last-word ordering:** the final word's write strobe precedes `CHECK` acceptance by at least one cycle, so memory is complete before `cpu_hold` falls.
- **`reset` mid-load:** reset has priority over `start` and over byte acceptance.

## Test plan

- **Two-word load:** stream 00 02 08 01 00 05 00 22 10 02 3C.
  - Writes: addr 0 = 0x08010005, then addr 1 = 0x00221002, each with a single-cycle `imem_we`.
  - `words_loaded` = 2; `done` = 1 and `cpu_hold` = 0 one cycle after 0x3C is accepted.
- **Bad checksum:** same stream with final byte 0x3D.
  - Both words are written; `error` = 1, `done` = 0, `cpu_hold` stays 1, `in_ready` = 0.
- **Empty and oversize counts:**
  - 00 00 00 → `done` = 1 with no `imem_we` pulse.
  - With ADDR_WIDTH = 7, 00 81 → `error` = 1 the cycle after 0x81 is accepted, and `in_ready` drops.
- **Backpressure gaps:** two-word stream with `in_valid` low for 3 cycles between each byte → identical writes and `done`; `imem_we` asserts only after each 4th byte.
- **`start` mid-load:** assert `start` after 6 bytes of the two-word stream, in the same cycle as a valid byte.
  - That byte is not consumed and `words_loaded` returns to 0.
  - A fresh full stream then produces addr 0 = 0x08010005, addr 1 = 0x00221002 and `done` = 1.
- **`reset` mid-load:** assert `reset` during `DATA` → all outputs at reset values on the next cycle, and `done`/`error` are cleared.
